// File: rtl/redun_mont_ctrl.sv
// Sequencer for repeated Montgomery squaring: feeds one operand at a time to an external
// squarer, chains results back in, and reports the final value, count and overflow status.
module redun_mont_ctrl #(
  parameter int unsigned W        = 1040,
  parameter int unsigned CNT_BITS = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [W-1:0]        i_init,
  input  logic [CNT_BITS-1:0] i_iters,
  input  logic                i_abort,
  output logic [W-1:0]        o_sq,
  output logic                o_sq_val,
  input  logic [W-1:0]        i_mul,
  input  logic                i_mul_val,
  input  logic                i_overflow,
  output logic                o_busy,
  output logic                o_done,
  output logic [W-1:0]        o_result,
  output logic [CNT_BITS-1:0] o_iter_cnt,
  output logic                o_error
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StErr} state_t;

  localparam logic [CNT_BITS-1:0] CntOne = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_t              state;
  logic [W-1:0]        op_reg;
  logic [CNT_BITS-1:0] iters_reg;
  logic [CNT_BITS-1:0] cnt_inc;

  // Saturating increment so the count never wraps.
  assign cnt_inc = (&o_iter_cnt) ? o_iter_cnt : o_iter_cnt + CntOne;

  assign o_busy = (state != StIdle);
  assign o_sq   = o_sq_val ? op_reg : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= StIdle;
      op_reg     <= '0;
      iters_reg  <= '0;
      o_sq_val   <= 1'b0;
      o_done     <= 1'b0;
      o_result   <= '0;
      o_iter_cnt <= '0;
      o_error    <= 1'b0;
    end else begin
      o_done   <= 1'b0;
      o_sq_val <= 1'b0;
      case (state)
        StIdle: begin
          if (i_start) begin
            o_error    <= 1'b0;
            o_iter_cnt <= '0;
            if (i_iters == '0) begin
              o_result <= i_init;
              o_done   <= 1'b1;
            end else begin
              iters_reg <= i_iters;
              op_reg    <= i_init;
              o_sq_val  <= 1'b1;
              state     <= StIssue;
            end
          end
        end
        StIssue: begin
          state <= i_abort ? StDrain : StWait;
        end
        StWait: begin
          if (i_abort) begin
            // A result arriving alongside the abort is dropped here, so no drain is needed.
            state <= i_mul_val ? StIdle : StDrain;
          end else if (i_mul_val) begin
            if (i_overflow) begin
              o_error <= 1'b1;
              state   <= StErr;
            end else begin
              o_iter_cnt <= cnt_inc;
              if (cnt_inc == iters_reg) begin
                o_result <= i_mul;
                o_done   <= 1'b1;
                state    <= StIdle;
              end else begin
                op_reg   <= i_mul;
                o_sq_val <= 1'b1;
                state    <= StIssue;
              end
            end
          end
        end
        StDrain: begin
          if (i_mul_val) state <= StIdle;
        end
        StErr: begin
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_redun_mont_ctrl.sv
// Randomized bench for redun_mont_ctrl: a latency-configurable modular squarer stands in for
// redun_mont, and each run is checked against an iterated-squaring reference.
module tb_redun_mont_ctrl;
  localparam int unsigned W  = 64;
  localparam int unsigned CB = 8;
  localparam logic [127:0] PRIME = (128'd1 << 61) - 128'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [W-1:0]  i_init = '0;
  logic [CB-1:0] i_iters = '0;
  logic          i_abort = 1'b0;
  logic [W-1:0]  o_sq;
  logic          o_sq_val;
  logic [W-1:0]  i_mul = '0;
  logic          i_mul_val = 1'b0;
  logic          i_overflow = 1'b0;
  logic          o_busy, o_done, o_error;
  logic [W-1:0]  o_result;
  logic [CB-1:0] o_iter_cnt;

  redun_mont_ctrl #(.W(W), .CNT_BITS(CB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_init(i_init), .i_iters(i_iters),
    .i_abort(i_abort), .o_sq(o_sq), .o_sq_val(o_sq_val), .i_mul(i_mul),
    .i_mul_val(i_mul_val), .i_overflow(i_overflow), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_iter_cnt(o_iter_cnt), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sq_mod(input logic [W-1:0] x);
    logic [127:0] t;
    t = {64'd0, x} * {64'd0, x};
    t = t % PRIME;
    return t[W-1:0];
  endfunction

  // Squarer model and protocol monitor state
  int           cyc = 0;
  int           lat = 1;
  int           ovf_idx = -1;
  int           abort_k = -1;
  int           res_idx = 0;
  int           n_sq = 0;
  int           n_done = 0;
  int           done_cyc = -1;
  int           gap_bad = 0;
  bit           first_issue = 0;
  bit           zero_run = 0;
  bit           pend = 0;
  int           pend_cnt = 0;
  logic [W-1:0] pend_op = '0;
  bit           prev_mul = 0;
  bit           abort_arm = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0; abort_arm = 0; prev_mul = 0;
      i_mul_val = 0; i_mul = '0; i_overflow = 0; i_abort = 0;
    end else begin
      cyc++;
      check_eq("sq_zero_when_idle", o_sq_val ? '0 : o_sq, '0);
      if (o_sq_val) begin
        n_sq++;
        if (pend) gap_bad++;
        if (!first_issue && !prev_mul) gap_bad++;
        first_issue = 0;
      end
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
        if (!prev_mul && !zero_run) gap_bad++;
      end
      i_abort = 0;
      if (abort_arm) begin abort_arm = 0; i_abort = 1; end
      i_mul_val = 0; i_mul = '0; i_overflow = 0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend = 0;
          i_mul_val = 1;
          i_mul = sq_mod(pend_op);
          i_overflow = (res_idx == ovf_idx);
          res_idx++;
        end
      end
      if (o_sq_val) begin
        pend = 1; pend_op = o_sq; pend_cnt = lat;
        if (n_sq == abort_k) abort_arm = 1;
      end
      prev_mul = i_mul_val;
    end
  end

  logic [W-1:0] exp_res = '0;

  task automatic run(input logic [W-1:0] init, input int iters, input int l, input int ovf,
                     input int abk, input bit glitch);
    bit completes, ovf_hit, finished;
    int exp_cnt, exp_sq, s0;
    logic [W-1:0] v;
    lat = l; ovf_idx = ovf; abort_k = abk; res_idx = 0; n_sq = 0; n_done = 0;
    gap_bad = 0; done_cyc = -1; first_issue = (iters > 0); zero_run = (iters == 0);
    ovf_hit   = (ovf >= 0) && (ovf < iters);
    completes = !ovf_hit && !((abk >= 1) && (abk <= iters));
    if (completes) begin
      v = init;
      for (int i = 0; i < iters; i++) v = sq_mod(v);
      exp_res = v; exp_cnt = iters; exp_sq = iters;
    end else if (ovf_hit) begin
      exp_cnt = ovf; exp_sq = ovf + 1;
    end else begin
      exp_cnt = abk - 1; exp_sq = abk;
    end
    @(posedge clk); #1;
    i_start = 1; i_init = init; i_iters = CB'(iters);
    @(posedge clk); #1;
    i_start = 0; i_init = '0; i_iters = '0;
    finished = 0; s0 = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (c == 0) begin
        s0 = cyc;
        check_eq("error_cleared_on_start", W'(o_error), '0);
      end
      if (glitch && c == 2) begin
        i_start = 1; i_init = {$urandom, $urandom}; i_iters = CB'($urandom_range(1, 9));
      end
      if (glitch && c == 3) begin i_start = 0; i_init = '0; i_iters = '0; end
      if (!o_busy && c >= (glitch ? 4 : 0)) begin finished = 1; break; end
    end
    check_eq("run_terminates", W'(finished), W'(1));
    repeat (3) @(negedge clk);
    #1;
    check_eq("done_count", W'(n_done), W'(completes));
    check_eq("sq_val_pulses", W'(n_sq), W'(exp_sq));
    check_eq("iter_cnt", W'(o_iter_cnt), W'(exp_cnt));
    check_eq("result", o_result, exp_res);
    check_eq("error_flag", W'(o_error), W'(ovf_hit));
    check_eq("handshake_latency", W'(gap_bad), '0);
    if (zero_run) check_eq("zero_iter_done_cycle", W'(done_cyc), W'(s0));
  endtask

  task automatic reset_mid_run();
    lat = 4; ovf_idx = -1; abort_k = -1; res_idx = 0; n_sq = 0;
    first_issue = 1; zero_run = 0;
    @(posedge clk); #1;
    i_start = 1; i_init = {$urandom, $urandom} % PRIME[W-1:0]; i_iters = CB'(5);
    @(posedge clk); #1;
    i_start = 0; i_init = '0; i_iters = '0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check_eq("rst_busy", W'(o_busy), '0);
    check_eq("rst_sq_val", W'(o_sq_val), '0);
    check_eq("rst_sq", o_sq, '0);
    check_eq("rst_done", W'(o_done), '0);
    check_eq("rst_result", o_result, '0);
    check_eq("rst_iter_cnt", W'(o_iter_cnt), '0);
    check_eq("rst_error", W'(o_error), '0);
    @(negedge clk); #2;
    rst_n = 1;
    exp_res = '0;
  endtask

  initial begin
    int mode, it, l, ovf, abk;
    logic [W-1:0] x;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_busy", W'(o_busy), '0);
    check_eq("reset_sq_val", W'(o_sq_val), '0);
    check_eq("reset_result", o_result, '0);
    check_eq("reset_iter_cnt", W'(o_iter_cnt), '0);
    check_eq("reset_error", W'(o_error), '0);
    check_eq("reset_done", W'(o_done), '0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    run(64'd2, 3, 5, -1, -1, 0);
    check_eq("two_pow_256", o_result, 64'd256);
    x = {$urandom, $urandom} % PRIME[W-1:0];
    run(x, 0, 3, -1, -1, 0);
    run({$urandom, $urandom} % PRIME[W-1:0], 4, 3, 1, -1, 0);
    run({$urandom, $urandom} % PRIME[W-1:0], 3, 2, -1, -1, 1);
    run({$urandom, $urandom} % PRIME[W-1:0], 10, 4, -1, 3, 0);
    run({$urandom, $urandom} % PRIME[W-1:0], 1, 2, -1, -1, 0);
    run({$urandom, $urandom} % PRIME[W-1:0], 5, 1, -1, 2, 0);
    reset_mid_run();
    run({$urandom, $urandom} % PRIME[W-1:0], 2, 3, -1, -1, 0);

    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 2);
      it   = $urandom_range(0, 6);
      l    = $urandom_range(1, 6);
      ovf  = -1;
      abk  = -1;
      if (it > 0 && mode == 1) ovf = $urandom_range(0, it - 1);
      if (it > 0 && mode == 2) abk = $urandom_range(1, it);
      run({$urandom, $urandom} % PRIME[W-1:0], it, l, ovf, abk,
          (ovf < 0) && (abk < 0) && (it >= 2) && ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
